// File: rtl/alu_mdu_seq.sv
// Registered ALU with iterative shift-add multiply and restoring divide producing HI/LO.
// Define ALU_DIV_EN to build the DIV/DIVU path; otherwise 1010/1011 decode as illegal ops.
module alu_mdu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluc,
  output logic             out_valid,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] hi,
  output logic             z,
  output logic             illegal
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd   = 4'b0000;
  localparam logic [3:0] OpAnd   = 4'b0001;
  localparam logic [3:0] OpXor   = 4'b0010;
  localparam logic [3:0] OpSll   = 4'b0011;
  localparam logic [3:0] OpSub   = 4'b0100;
  localparam logic [3:0] OpOr    = 4'b0101;
  localparam logic [3:0] OpLui   = 4'b0110;
  localparam logic [3:0] OpSrl   = 4'b0111;
  localparam logic [3:0] OpSlt   = 4'b1100;
  localparam logic [3:0] OpSltu  = 4'b1101;
  localparam logic [3:0] OpNor   = 4'b1110;
  localparam logic [3:0] OpSra   = 4'b1111;
`ifndef ALU_DIV_EN
  localparam logic [3:0] OpDiv   = 4'b1010;
  localparam logic [3:0] OpDivu  = 4'b1011;
`endif

`ifdef ALU_DIV_EN
  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;
`else
  typedef enum logic [1:0] {StIdle, StMul} state_e;
`endif

  state_e               state_q, state_d;
  logic [SHW-1:0]       count_q, count_d;
  logic [2*WIDTH-1:0]   p_q, p_d;         // {acc/rem, multiplier/quotient}
  logic [WIDTH-1:0]     mcand_q, mcand_d; // multiplicand or divisor magnitude
  logic                 neg_lo_q, neg_lo_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     r_q, r_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic                 z_q, z_d;
  logic                 illegal_q, illegal_d;

  logic [SHW-1:0]       shamt;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_ill;
  logic                 is_mul;
  logic                 is_signed;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step;
  logic [2*WIDTH-1:0]   mul_prod;

  assign shamt     = a[SHW-1:0];
  assign is_mul    = (aluc[3:1] == 3'b100);
  assign is_signed = ~aluc[0];
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // One shift-add step: add multiplicand on multiplier LSB, then shift the pair right.
  assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_step = {mul_sum, p_q[WIDTH-1:1]};
  assign mul_prod = neg_lo_q ? -mul_step : mul_step;

`ifdef ALU_DIV_EN
  logic                 is_div;
  logic                 neg_hi_q, neg_hi_d;
  logic                 divz_q, divz_d;
  logic [WIDTH-1:0]     a_keep_q, a_keep_d;
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_sub;
  logic [2*WIDTH-1:0]   div_step;
  logic [WIDTH-1:0]     div_quo, div_rem;

  assign is_div    = (aluc[3:1] == 3'b101);
  // Restoring step: bring in next dividend bit, subtract divisor if it fits.
  assign div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, mcand_q});
  assign div_sub   = div_shift[WIDTH-1:0] - mcand_q;
  assign div_step  = div_ge ? {div_sub, p_q[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
  assign div_quo   = neg_lo_q ? -div_step[WIDTH-1:0] : div_step[WIDTH-1:0];
  assign div_rem   = neg_hi_q ? -div_step[2*WIDTH-1:WIDTH] : div_step[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (aluc)
      OpAdd:  alu_res = a + b;
      OpSub:  alu_res = a - b;
      OpAnd:  alu_res = a & b;
      OpOr:   alu_res = a | b;
      OpXor:  alu_res = a ^ b;
      OpNor:  alu_res = ~(a | b);
      OpLui:  alu_res = b << (WIDTH / 2);
      OpSll:  alu_res = b << shamt;
      OpSrl:  alu_res = b >> shamt;
      OpSra:  alu_res = $signed(b) >>> shamt;
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OpSltu: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
`ifndef ALU_DIV_EN
      OpDiv, OpDivu: alu_ill = 1'b1;
`endif
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    p_d         = p_q;
    mcand_d     = mcand_q;
    neg_lo_d    = neg_lo_q;
    out_valid_d = 1'b0;
    r_d         = r_q;
    hi_d        = hi_q;
    z_d         = z_q;
    illegal_d   = illegal_q;
`ifdef ALU_DIV_EN
    neg_hi_d    = neg_hi_q;
    divz_d      = divz_q;
    a_keep_d    = a_keep_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (is_mul) begin
            mcand_d  = a_mag;
            p_d      = {{WIDTH{1'b0}}, b_mag};
            neg_lo_d = a_neg ^ b_neg;
            count_d  = '0;
            state_d  = StMul;
          end
`ifdef ALU_DIV_EN
          else if (is_div) begin
            mcand_d  = b_mag;
            p_d      = {{WIDTH{1'b0}}, a_mag};
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
            divz_d   = (b == '0);
            a_keep_d = a;
            count_d  = '0;
            state_d  = StDiv;
          end
`endif
          else begin
            out_valid_d = 1'b1;
            r_d         = alu_res;
            hi_d        = '0;
            z_d         = (alu_res == '0);
            illegal_d   = alu_ill;
          end
        end
      end
      StMul: begin
        p_d     = mul_step;
        count_d = count_q + SHW'(1);
        if (count_q == SHW'(WIDTH - 1)) begin
          state_d     = StIdle;
          count_d     = '0;
          out_valid_d = 1'b1;
          r_d         = mul_prod[WIDTH-1:0];
          hi_d        = mul_prod[2*WIDTH-1:WIDTH];
          z_d         = (mul_prod[WIDTH-1:0] == '0);
          illegal_d   = 1'b0;
        end
      end
`ifdef ALU_DIV_EN
      StDiv: begin
        p_d     = div_step;
        count_d = count_q + SHW'(1);
        if (count_q == SHW'(WIDTH - 1)) begin
          state_d     = StIdle;
          count_d     = '0;
          out_valid_d = 1'b1;
          illegal_d   = 1'b0;
          // Divide by zero: quotient all ones, remainder is the raw dividend.
          if (divz_q) begin
            r_d  = '1;
            hi_d = a_keep_q;
            z_d  = 1'b0;
          end else begin
            r_d  = div_quo;
            hi_d = div_rem;
            z_d  = (div_quo == '0);
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      p_q         <= '0;
      mcand_q     <= '0;
      neg_lo_q    <= 1'b0;
      out_valid_q <= 1'b0;
      r_q         <= '0;
      hi_q        <= '0;
      z_q         <= 1'b1;
      illegal_q   <= 1'b0;
`ifdef ALU_DIV_EN
      neg_hi_q    <= 1'b0;
      divz_q      <= 1'b0;
      a_keep_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      p_q         <= p_d;
      mcand_q     <= mcand_d;
      neg_lo_q    <= neg_lo_d;
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
      hi_q        <= hi_d;
      z_q         <= z_d;
      illegal_q   <= illegal_d;
`ifdef ALU_DIV_EN
      neg_hi_q    <= neg_hi_d;
      divz_q      <= divz_d;
      a_keep_q    <= a_keep_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign hi        = hi_q;
  assign z         = z_q;
  assign illegal   = illegal_q;

endmodule
